// File: rtl/sign_extend_pkg.sv
// -----------------------------------------------------------------------------
// sign_extend_pkg
// Shared definitions for the immediate-extension unit: the extension mode
// encoding, the default field/word widths and the short sub-field width.
// -----------------------------------------------------------------------------
package sign_extend_pkg;

  // Default raw immediate width and datapath word width.
  localparam int IN_W_DEF  = 22;
  localparam int OUT_W_DEF = 32;

  // Width of the narrow sub-field used by the 16-bit modes.
  localparam int SHORT_W   = 16;

  // Extension mode as presented on the 2-bit mode input.
  typedef enum logic [1:0] {
    SEXT22      = 2'd0,  // sign-extend full field
    ZEXT22      = 2'd1,  // zero-extend full field
    SEXT16      = 2'd2,  // sign-extend low 16 bits
    SEXT16_SHL2 = 2'd3   // sign-extend low 16 bits, then shift left by 2
  } ext_mode_e;

endpackage : sign_extend_pkg

// File: rtl/sign_extend_core.sv
// -----------------------------------------------------------------------------
// sign_extend_core
// Stateless mode mux that widens an IN_W immediate to an OUT_W word.
//
// Ports
//   mode    in  2      extension mode (sign_extend_pkg::ext_mode_e encoding)
//   imm_in  in  IN_W   raw immediate field
//   ext_out out OUT_W  extended value (combinational)
//
// IN_W must be at least SHORT_W and OUT_W must exceed IN_W.
// -----------------------------------------------------------------------------
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  imm_in,
  output logic [OUT_W-1:0] ext_out
);

  ext_mode_e        mode_s;
  logic [OUT_W-1:0] sext_full_s;
  logic [OUT_W-1:0] zext_full_s;
  logic [OUT_W-1:0] sext_short_s;
  logic [OUT_W-1:0] sext_short_shl_s;
  logic [OUT_W-1:0] ext_s;

  assign mode_s = ext_mode_e'(mode);

  // All four candidates are built in parallel; the mux below only selects.
  assign sext_full_s  = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
  assign zext_full_s  = {{(OUT_W-IN_W){1'b0}}, imm_in};
  assign sext_short_s = {{(OUT_W-SHORT_W){imm_in[SHORT_W-1]}}, imm_in[SHORT_W-1:0]};

  // Branch-offset form: the two top bits of the short result fall off the
  // end, which is the intended truncation to the word width.
  assign sext_short_shl_s = {sext_short_s[OUT_W-3:0], 2'b00};

  // Select the extension requested for this sample.
  always_comb begin
    ext_s = {OUT_W{1'b0}};
    case (mode_s)
      SEXT22:      ext_s = sext_full_s;
      ZEXT22:      ext_s = zext_full_s;
      SEXT16:      ext_s = sext_short_s;
      SEXT16_SHL2: ext_s = sext_short_shl_s;
      default:     ext_s = {OUT_W{1'b0}};
    endcase
  end

  assign ext_out = ext_s;

endmodule : sign_extend_core

// File: rtl/sign_extend.sv
// -----------------------------------------------------------------------------
// sign_extend
// Registered immediate-extension unit between decode and the ALU operand mux.
// Each accepted input produces its extended value one clock later.
//
// Ports
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      mode/imm_in are valid this cycle
//   mode      in  2      extension mode (sign_extend_pkg::ext_mode_e)
//   imm_in    in  IN_W   raw immediate field
//   out_valid out 1      imm_out holds a new result this cycle
//   imm_out   out OUT_W  extended immediate (held while no new result)
// -----------------------------------------------------------------------------
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  imm_in,
  output logic             out_valid,
  output logic [OUT_W-1:0] imm_out
);

  logic [OUT_W-1:0] ext_s;
  logic [OUT_W-1:0] imm_out_r;
  logic             out_valid_r;

  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode    (mode),
    .imm_in  (imm_in),
    .ext_out (ext_s)
  );

  // Output stage: capture on valid, otherwise hold the data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_out_r   <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      imm_out_r   <= ext_s;
      out_valid_r <= 1'b1;
    end else begin
      imm_out_r   <= imm_out_r;
      out_valid_r <= 1'b0;
    end
  end

  assign imm_out   = imm_out_r;
  assign out_valid = out_valid_r;

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mode;
  logic [21:0] imm_in;
  logic        out_valid;
  logic [31:0] imm_out;

  int total;
  int bad;
  bit check_en;

  logic [31:0] exp_out;
  logic        exp_valid;

  sign_extend #(.IN_W(22), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .imm_in    (imm_in),
    .out_valid (out_valid),
    .imm_out   (imm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the field as a number, extend arithmetically.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [21:0] v);
    longint x;
    x = longint'(v);
    case (m)
      2'd0: if (x >= 64'sd2097152) x = x - 64'sd4194304;
      2'd1: x = x;
      default: begin
        x = x % 64'sd65536;
        if (x >= 64'sd32768) x = x - 64'sd65536;
        if (m == 2'd3) x = x * 64'sd4;
      end
    endcase
    return x[31:0];
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, req, $time);
    end
  endtask

  // Model state: one-cycle delayed result, held data, async clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out   = 32'h0;
      exp_valid = 1'b0;
    end else if (in_valid) begin
      exp_out   = model(mode, imm_in);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check1("cyc_valid", out_valid, exp_valid);
      check32("cyc_data", imm_out, exp_out);
    end
  end

  // Drive one valid sample and check the literal result one cycle later.
  task automatic send(input string name, input logic [1:0] m, input logic [21:0] v,
                      input logic [31:0] req);
    in_valid = 1'b1;
    mode     = m;
    imm_in   = v;
    check32({name, "_model"}, model(m, v), req);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1({name, "_valid"}, out_valid, 1'b1);
    check32(name, imm_out, req);
  endtask

  task automatic idle(input string name, input logic [31:0] hold);
    in_valid = 1'b0;
    mode     = 2'($urandom_range(0, 3));
    imm_in   = 22'($urandom);
    @(posedge clk);
    #1;
    check1({name, "_valid"}, out_valid, 1'b0);
    check32({name, "_hold"}, imm_out, hold);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    mode     = 2'd0;
    imm_in   = 22'h000016;

    // Reset held across clock edges even with valid input present.
    repeat (3) @(posedge clk);
    #1;
    check1("rst_valid", out_valid, 1'b0);
    check32("rst_data", imm_out, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    check1("post_rst_valid", out_valid, 1'b0);
    check32("post_rst_data", imm_out, 32'h0);

    // Mode 0 back-to-back
    send("m0_22",   2'd0, 22'h000016, 32'h00000016);
    send("m0_m22",  2'd0, 22'h3FFFEA, 32'hFFFFFFEA);
    send("m0_63",   2'd0, 22'h00003F, 32'h0000003F);
    send("m0_m45",  2'd0, 22'h3FFFD3, 32'hFFFFFFD3);
    // Mode 1
    send("m1_neg",  2'd1, 22'h3FFFEA, 32'h003FFFEA);
    send("m1_pos",  2'd1, 22'h000016, 32'h00000016);
    // Mode 2 / 3 (mode changes every sample)
    send("m2_neg",  2'd2, 22'h3F8000, 32'hFFFF8000);
    send("m2_pos",  2'd2, 22'h007FFF, 32'h00007FFF);
    send("m3_neg",  2'd3, 22'h00FFFF, 32'hFFFFFFFC);
    send("m3_pos",  2'd3, 22'h000010, 32'h00000040);
    send("m3_trunc",2'd3, 22'h3F4000, 32'h00010000);
    send("m2_hi",   2'd2, 22'h3C1234, 32'h00001234);
    // Mode 0 boundaries
    send("m0_maxp", 2'd0, 22'h1FFFFF, 32'h001FFFFF);
    send("m0_minn", 2'd0, 22'h200000, 32'hFFE00000);
    send("m0_ones", 2'd0, 22'h3FFFFF, 32'hFFFFFFFF);
    send("m0_zero", 2'd0, 22'h000000, 32'h00000000);

    // Valid gap: 1,0,1 with data held
    send("gap_a",   2'd0, 22'h000016, 32'h00000016);
    idle("gap_idle", 32'h00000016);
    send("gap_b",   2'd0, 22'h3FFFEA, 32'hFFFFFFEA);
    idle("gap_idle2", 32'hFFFFFFEA);

    // Async reset mid-stream: clears between edges
    in_valid = 1'b1;
    mode     = 2'd1;
    imm_in   = 22'h2AAAAA;
    @(posedge clk);
    #1;
    check32("pre_arst", imm_out, 32'h002AAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_valid", out_valid, 1'b0);
    check32("arst_data", imm_out, 32'h0);
    @(posedge clk);
    #1;
    check1("arst_hold_valid", out_valid, 1'b0);
    check32("arst_hold_data", imm_out, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    send("first_after", 2'd0, 22'h200001, 32'hFFE00001);

    // Random back-to-back with random gaps, checked by the compare process.
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      mode     = 2'($urandom_range(0, 3));
      imm_in   = 22'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sign_extend

// File: doc/sign_extend.md
# sign_extend

Registered immediate-extension unit that widens a 22-bit instruction immediate field to the 32-bit datapath word. It sits between instruction decode and the ALU operand mux. It supports sign- and zero-extension of the full field and of narrower sub-fields. The result is presented one clock after the input is accepted, alongside a valid flag.

## Interface
- `IN_W`, default 22: input immediate width.
- `OUT_W`, default 32: output word width; must be greater than `IN_W`.
- `clk  input  1`: rising-edge clock.
- `rst_n  input  1`: reset; asynchronous, active-low.
- `in_valid  input  1`: `imm_in`/`mode` are valid this cycle.
- `mode  input  2`: extension mode (see Operation).
- `imm_in  input  IN_W`: raw immediate field, two's complement when signed.
- `out_valid  output  1`: `imm_out` holds a new result this cycle.
- `imm_out  output  OUT_W`: extended immediate.
- One clock; reset is asynchronous and active-low.

## Operation
- Mode 0, SEXT22: replicate `imm_in[IN_W-1]` into bits `[OUT_W-1:IN_W]`.
- Mode 1, ZEXT22: upper bits are zero.
- Mode 2, SEXT16: use `imm_in[15:0]` only and replicate bit 15; `imm_in[21:16]` is ignored.
- Mode 3, SEXT16_SHL2: SEXT16 result shifted left 2, for branch offsets; the two LSBs are 0 and overflow bits are discarded (truncate to `OUT_W`).
- The extension is pure combinational logic, followed by one output register stage.
- `in_valid`=1 at a clock edge: `imm_out` <= extended value and `out_valid` <= 1.
- `in_valid`=0 at a clock edge: `imm_out` holds its previous value and `out_valid` <= 0.
- Inputs with X are not required to be handled while `in_valid`=0.
- No backpressure: every valid input is accepted, and back-to-back valid cycles produce back-to-back results.

## Timing
- Latency is exactly 1 cycle: input sampled at edge N appears on `imm_out`/`out_valid` after edge N.
- Throughput is 1 result per cycle.
- Reset values: `imm_out` = 0 and `out_valid` = 0.
- Asserting `rst_n` low mid-operation clears both outputs immediately, without waiting for a clock edge. Any pending result is dropped.
- First capture is at the first rising edge after `rst_n` deasserts.
- Boundary values, mode 0: 0x1FFFFF -> 0x001FFFFF; 0x200000 -> 0xFFE00000; 0x3FFFFF -> 0xFFFFFFFF; 0 -> 0.
- `mode` changing between consecutive valid cycles takes effect per-sample. There is no sticky mode state.

## Structure
- Package `sign_extend_pkg` holds:
  - the mode enum (`SEXT22`, `ZEXT22`, `SEXT16`, `SEXT16_SHL2`) with width 2;
  - default `IN_W`/`OUT_W` constants;
  - `SHORT_W` = 16.
- The combinational core is the sub-module `sign_extend_core`, a mode mux with no state.
- The top module adds the register stage and reset.

## Test plan
- Reset: hold `rst_n`=0, then release -> `imm_out`=0, `out_valid`=0. Assert reset mid-stream -> both clear asynchronously.
- Mode 0 sequence, one value per cycle:
  - 22 -> 0x00000016
  - -22 (0x3FFFEA) -> 0xFFFFFFEA
  - 63 -> 0x0000003F
  - -45 (0x3FFFD3) -> 0xFFFFFFD3
  - each with `out_valid`=1 exactly one cycle after input.
- Mode 1: 0x3FFFEA -> 0x003FFFEA. Mode 1: 0x000016 -> 0x00000016.
- Mode 2: 0x3F8000 -> 0xFFFF8000. Mode 2: 0x007FFF -> 0x00007FFF. Mode 3: 0x00FFFF -> 0xFFFFFFFC. Mode 3: 0x000010 -> 0x00000040.
- Mode 0 boundaries: 0x1FFFFF -> 0x001FFFFF. 0x200000 -> 0xFFE00000.
- Valid gaps: valid 22, idle, valid -22 -> `out_valid` pattern 1,0,1; `imm_out` holds 0x16 during the idle cycle.
